device_seq: RTL and testbench
=============================

# device_seq

Command-driven sequencer for the 4-bit mode-selected register `device`, whose controls are `PE[1:0]` (operation) and `D[3:0]` (data), with output `Q[3:0]`. It accepts one operation at a time over a valid/ready handshake and expands it into a run of cycles with the correct `PE`/`D` drive. A shadow copy of the expected register contents is checked against `Q` after every command, and the result is reported as a done pulse plus a sticky mismatch flag.

## Interface
- `WIDTH`, 4: data width of `D`, `Q`, `cmd_data` and the shadow register.
- `CNTW`, 3: width of the repeat count `cmd_cnt`.

- `clk`  in  1  Single clock; all state changes on its rising edge.
- `r`  in  1  Reset. Synchronous, active-high.
- `cmd_valid`  in  1  Command present.
- `cmd_ready`  out  1  Sequencer idle; can accept a command.
- `cmd_op`  in  2  Operation: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- `cmd_data`  in  WIDTH  Load value. Used only when `cmd_op`=11.
- `cmd_cnt`  in  CNTW  Repeat count. The operation runs for `cmd_cnt`+1 cycles. Ignored for load, which always runs 1 cycle.
- `PE`  out  2  Mode drive to the device. Registered.
- `D`  out  WIDTH  Data drive to the device. Registered.
- `Q`  in  WIDTH  Device output, used for checking.
- `busy`  out  1  Command in progress (RUN or CHECK state).
- `done`  out  1  One-cycle pulse in the CHECK cycle.
- `mismatch`  out  1  Sticky flag: `Q` differed from the shadow at a check. Cleared only by `r`.

## Operation
- **FSM states:** IDLE, RUN, CHECK.
- **IDLE:**
  - `cmd_ready`=1, `busy`=0, `PE`=00, `D`=0.
  - On `cmd_valid`&&`cmd_ready`, capture op, data and count; the remaining-cycle counter is loaded with `cmd_cnt` (0 for load). Next state is RUN.
- **RUN:**
  - `PE` = captured op. `D` = captured data for load, 0 otherwise.
  - Shadow update each RUN cycle:
    - load: `shadow`=`data`;
    - shift left: `shadow`={`shadow`[WIDTH-2:0],0}, MSB dropped;
    - shift right: `shadow`={0,`shadow`[WIDTH-1:1]}, LSB dropped;
    - hold: unchanged.
  - Counter decrements each RUN cycle. When it reads 0 in a RUN cycle, that is the last RUN cycle and the next state is CHECK.
- **CHECK:**
  - `PE`=00, `D`=0, `done`=1.
  - If `Q`!=`shadow`, set `mismatch`.
  - Next state is IDLE.
- **Device contract:** the device applies `PE`/`D` at the same clock edge the sequencer updates the shadow, so in CHECK `Q` must equal the shadow.
- **Command blocking:** `cmd_valid` is ignored while `cmd_ready`=0. No queuing; the requester holds its command until accepted.
- **Counter range:** the counter never wraps. `cmd_cnt`=2^CNTW-1 gives 2^CNTW RUN cycles.

## Timing
- **Reset values:** state IDLE, `PE`=00, `D`=0, `cmd_ready`=1, `busy`=0, `done`=0, `mismatch`=0, `shadow`=0, counter 0.
- **Reset with the device:** `r` must be applied together with the device's own reset so that both start at 0.
- **Command timeline** (accept at edge k, N = `cmd_cnt`+1, or 1 for load):
  - RUN outputs are visible during cycles k+1 … k+N;
  - CHECK / `done` during cycle k+N+1;
  - `cmd_ready`=1 again from cycle k+N+2.
- **Latency and throughput:** accept to `done` is N+1 cycles. Maximum throughput is one command per N+2 cycles.
- **`cmd_ready`:** combinational from state (IDLE).
- **Reset mid-operation:** `r`=1 in any state returns the block to reset values at the next edge. No `done` is issued for the aborted command, and `mismatch` is cleared.
- **`done` and `mismatch` together:** a mismatch detected in CHECK is visible the cycle after `done`.

## Test plan
- **Reset:** `r`=1 for 2 cycles with `cmd_valid`=1.
  - Required: `PE`=00, `D`=0, `cmd_ready`=1, `busy`=0, `done`=0, `mismatch`=0, and no command accepted.
- **Load:** load `cmd_data`=4'hA with `cmd_cnt`=5.
  - Required: exactly one RUN cycle with `PE`=11 and `D`=A.
  - Required: `done` at k+2, shadow=A, and with the device attached `mismatch` stays 0.
- **Shift left:** after loading A, shift left with `cmd_cnt`=2.
  - Required: `PE`=01 for 3 cycles; shadow goes 1010→0100→1000→0000; `done` at k+4; `cmd_ready` returns at k+5.
- **Shift right then hold:** shift right `cmd_cnt`=0 from 4'h9, then hold `cmd_cnt`=3.
  - Required: shadow 0100 after the shift, unchanged through the hold.
  - Required: `PE`=10 for 1 cycle, then `PE`=00 for 4 RUN cycles; both `done` pulses at their computed cycles.
- **Mismatch:** behavioural `Q` model forced to 4'h5 when the shadow is 4'h0.
  - Required: `mismatch`=1 the cycle after CHECK, still 1 after the next command completes, cleared only by `r`.
- **Reset mid-RUN:** `r`=1 during the 2nd RUN cycle of a shift with `cmd_cnt`=7.
  - Required: next cycle state IDLE, `PE`=00, no `done`, `cmd_ready`=1.
  - Required: `cmd_valid` held high throughout is not accepted until after reset is released.

Source files
------------

// File: rtl/device_seq.sv
// device_seq: command-driven sequencer for a 4-bit mode-selected register.
// Accepts one operation over valid/ready, expands it into RUN cycles driving
// PE/D, keeps a shadow of the expected register contents, and compares it
// against the device output Q in a single CHECK cycle per command.
module device_seq #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             r,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNTW-1:0]  cmd_cnt,
  output logic [1:0]       PE,
  output logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_CHECK = 2'b10
  } state_t;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_SHL   = 2'b01;
  localparam logic [1:0] OP_SHR   = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};
  localparam logic [CNTW-1:0]  CNT_ZERO  = {CNTW{1'b0}};
  localparam logic [CNTW-1:0]  CNT_ONE   = CNTW'(1);

  state_t           state_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNTW-1:0]  cnt_r;
  logic [WIDTH-1:0] shadow_r;
  logic [1:0]       pe_r;
  logic [WIDTH-1:0] d_r;
  logic             done_r;
  logic             mismatch_r;
  logic             cmd_ready_s;
  logic             busy_s;

  // Next shadow value for one RUN cycle of the given operation; mirrors
  // exactly what the device does with the same PE/D drive.
  function automatic logic [WIDTH-1:0] shadow_next(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] data,
    input logic [WIDTH-1:0] cur
  );
    logic [WIDTH-1:0] nxt;
    case (op)
      OP_HOLD: nxt = cur;
      OP_SHL:  nxt = {cur[WIDTH-2:0], 1'b0};
      OP_SHR:  nxt = {1'b0, cur[WIDTH-1:1]};
      OP_LOAD: nxt = data;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Handshake and status decode straight from the state register.
  always_comb begin
    cmd_ready_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      S_IDLE:  cmd_ready_s = 1'b1;
      S_RUN:   busy_s      = 1'b1;
      S_CHECK: busy_s      = 1'b1;
      default: begin
        cmd_ready_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // Sequencer FSM: command capture, RUN expansion with shadow tracking, CHECK.
  always_ff @(posedge clk) begin
    if (r) begin
      state_r    <= S_IDLE;
      op_r       <= OP_HOLD;
      data_r     <= DATA_ZERO;
      cnt_r      <= CNT_ZERO;
      shadow_r   <= DATA_ZERO;
      pe_r       <= OP_HOLD;
      d_r        <= DATA_ZERO;
      done_r     <= 1'b0;
      mismatch_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          pe_r   <= OP_HOLD;
          d_r    <= DATA_ZERO;
          if (cmd_valid) begin
            op_r    <= cmd_op;
            data_r  <= cmd_data;
            state_r <= S_RUN;
            pe_r    <= cmd_op;
            if (cmd_op == OP_LOAD) begin
              // A load always occupies exactly one RUN cycle.
              cnt_r <= CNT_ZERO;
              d_r   <= cmd_data;
            end else begin
              cnt_r <= cmd_cnt;
              d_r   <= DATA_ZERO;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          // The device applies this cycle's PE/D at this same edge.
          shadow_r <= shadow_next(op_r, data_r, shadow_r);
          if (cnt_r == CNT_ZERO) begin
            state_r <= S_CHECK;
            pe_r    <= OP_HOLD;
            d_r     <= DATA_ZERO;
            done_r  <= 1'b1;
          end else begin
            // Only decrement while non-zero so the counter never wraps.
            cnt_r   <= cnt_r - CNT_ONE;
            state_r <= S_RUN;
          end
        end
        S_CHECK: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
          if (Q != shadow_r) begin
            mismatch_r <= 1'b1;
          end else begin
            mismatch_r <= mismatch_r;
          end
        end
        default: begin
          state_r <= S_IDLE;
          pe_r    <= OP_HOLD;
          d_r     <= DATA_ZERO;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_s;
  assign busy      = busy_s;
  assign PE        = pe_r;
  assign D         = d_r;
  assign done      = done_r;
  assign mismatch  = mismatch_r;

endmodule

// File: tb/tb_device_seq.sv
// Self-checking bench for device_seq: a behavioural device model, a table of
// commands with hand-derived final register values, and hand-written
// sequences for mismatch and mid-RUN reset.
module tb_device_seq;

  logic       clk = 1'b0;
  logic       r;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic [1:0] PE;
  logic [3:0] D;
  logic [3:0] Q;
  logic       busy;
  logic       done;
  logic       mismatch;

  logic [3:0] dev_q;
  logic       force_q;

  int total = 0;
  int bad   = 0;

  logic [3:0] sb_q[$];

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] cnt;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  device_seq #(.WIDTH(4), .CNTW(3)) dut (
    .clk(clk), .r(r), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .PE(PE), .D(D), .Q(Q), .busy(busy), .done(done), .mismatch(mismatch)
  );

  // Behavioural mode-selected register, reset together with the sequencer.
  always @(posedge clk) begin
    if (r) dev_q <= 4'h0;
    else begin
      case (PE)
        2'b01:   dev_q <= {dev_q[2:0], 1'b0};
        2'b10:   dev_q <= {1'b0, dev_q[3:1]};
        2'b11:   dev_q <= D;
        default: dev_q <= dev_q;
      endcase
    end
  end

  assign Q = force_q ? 4'h5 : dev_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command and check every cycle of its timeline.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] data,
                        input logic [2:0] cnt, input logic [3:0] exp_q,
                        input logic exp_mm);
    int n;
    int tries;
    logic [3:0] got;
    @(negedge clk);
    cmd_op = op; cmd_data = data; cmd_cnt = cnt; cmd_valid = 1'b1;
    tries = 0;
    while (!cmd_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    chk("accept_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = (op == 2'b11) ? 1 : int'(cnt) + 1;
    sb_q.push_back(exp_q);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("run_pe", {30'b0, PE}, {30'b0, op});
      chk("run_d", {28'b0, D}, (op == 2'b11) ? {28'b0, data} : 32'd0);
      chk("run_busy", {31'b0, busy}, 32'd1);
      chk("run_done", {31'b0, done}, 32'd0);
      chk("run_ready", {31'b0, cmd_ready}, 32'd0);
    end
    @(negedge clk);
    chk("check_done", {31'b0, done}, 32'd1);
    chk("check_pe", {30'b0, PE}, 32'd0);
    chk("check_d", {28'b0, D}, 32'd0);
    chk("check_busy", {31'b0, busy}, 32'd1);
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue want one entry");
    end else begin
      got = sb_q.pop_front();
      chk("check_q", {28'b0, Q}, {28'b0, got});
    end
    @(negedge clk);
    chk("after_ready", {31'b0, cmd_ready}, 32'd1);
    chk("after_busy", {31'b0, busy}, 32'd0);
    chk("after_done", {31'b0, done}, 32'd0);
    chk("after_mismatch", {31'b0, mismatch}, {31'b0, exp_mm});
  endtask

  initial begin
    int tries;
    r = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'hF; cmd_cnt = 3'd0;
    force_q = 1'b0;

    // Reset held two cycles with a command presented.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_pe", {30'b0, PE}, 32'd0);
      chk("rst_d", {28'b0, D}, 32'd0);
      chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_mismatch", {31'b0, mismatch}, 32'd0);
    end
    r = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", {31'b0, busy}, 32'd0);

    // Command table; final register values worked out by hand.
    vecs[0]  = '{2'b11, 4'hA, 3'd5, 4'hA};
    vecs[1]  = '{2'b01, 4'h0, 3'd2, 4'h0};
    vecs[2]  = '{2'b11, 4'h9, 3'd0, 4'h9};
    vecs[3]  = '{2'b10, 4'h0, 3'd0, 4'h4};
    vecs[4]  = '{2'b00, 4'h0, 3'd3, 4'h4};
    vecs[5]  = '{2'b11, 4'h3, 3'd7, 4'h3};
    vecs[6]  = '{2'b10, 4'h0, 3'd7, 4'h0};
    vecs[7]  = '{2'b11, 4'hF, 3'd0, 4'hF};
    vecs[8]  = '{2'b01, 4'h0, 3'd1, 4'hC};
    vecs[9]  = '{2'b10, 4'h0, 3'd0, 4'h6};
    vecs[10] = '{2'b00, 4'h0, 3'd0, 4'h6};
    for (int i = 0; i < 11; i++) begin
      do_cmd(vecs[i].op, vecs[i].data, vecs[i].cnt, vecs[i].exp_q, 1'b0);
    end

    // Mismatch: shadow is 0 after reset, device output forced to 5.
    @(negedge clk); r = 1'b1;
    @(negedge clk); r = 1'b0; force_q = 1'b1;
    do_cmd(2'b00, 4'h0, 3'd0, 4'h5, 1'b1);
    force_q = 1'b0;
    do_cmd(2'b11, 4'h7, 3'd0, 4'h7, 1'b1);
    @(negedge clk);
    chk("mm_sticky", {31'b0, mismatch}, 32'd1);
    r = 1'b1;
    @(negedge clk);
    chk("mm_cleared", {31'b0, mismatch}, 32'd0);
    r = 1'b0;

    // Reset during the 2nd RUN cycle of a long shift, command held high.
    @(negedge clk);
    cmd_op = 2'b01; cmd_data = 4'h0; cmd_cnt = 3'd7; cmd_valid = 1'b1;
    @(negedge clk);
    chk("mid_run1_pe", {30'b0, PE}, 32'd1);
    chk("mid_run1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("mid_run2_pe", {30'b0, PE}, 32'd1);
    r = 1'b1;
    @(negedge clk);
    chk("mid_rst_pe", {30'b0, PE}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    chk("mid_rst_hold_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_hold_done", {31'b0, done}, 32'd0);
    r = 1'b0;
    @(negedge clk);
    chk("post_rst_accept", {31'b0, busy}, 32'd1);
    chk("post_rst_pe", {30'b0, PE}, 32'd1);
    cmd_valid = 1'b0;
    tries = 0;
    while (!cmd_ready && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    chk("post_rst_finish", {31'b0, cmd_ready}, 32'd1);
    chk("post_rst_no_mm", {31'b0, mismatch}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
